row_buf_sequencer: RTL and testbench
====================================

ROW_BUF_SEQUENCER -- requirements
Module: row_buf_sequencer

Interface
REQ-001 Parameter ROW, default 9: rows per tile.
REQ-002 Parameter COL, default 3: columns per tile.
REQ-003 Parameter W_ADDR, default 8: FIFO address width; the occupancy port is W_ADDR+1 bits.
REQ-004 Parameter BURST_LEN, default ROW: FIFO reads per burst, range 1 to 2^16-1.
REQ-005 Parameter THRESHOLD, default ROW*COL: minimum occupancy that starts a burst, range 1 to 2^(W_ADDR+1)-1.
REQ-006 Parameter GAP, default 2: idle cycles after each burst, 0 allowed.
REQ-007 Parameter W_CNT, default 8: width of the completed-burst counter.
REQ-008 One clock; reset is synchronous and active-high.
REQ-009 i_clk  in  1  clock; all state changes on its rising edge.
REQ-010 i_rst  in  1  synchronous active-high reset.
REQ-011 i_enable  in  1  arms the sequencer; sampled only in IDLE and HOLD.
REQ-012 i_mode  in  1  0 = single-shot, 1 = continuous; latched at burst start.
REQ-013 i_fifo_empty  in  1  FIFO empty flag.
REQ-014 i_occupants  in  W_ADDR+1  FIFO occupancy.
REQ-015 i_sr_ready  in  1  downstream shift register can accept a word.
REQ-016 o_read_enable  out  1  FIFO read strobe; combinational.
REQ-017 o_sr_enable  out  1  shift-register load strobe; registered.
REQ-018 o_busy  out  1  high in BURST and GAP.
REQ-019 o_burst_done  out  1  one-cycle pulse per completed burst; registered.
REQ-020 o_burst_count  out  W_CNT  completed bursts, modulo 2^W_CNT.
REQ-021 o_beat_idx  out  clog2(BURST_LEN+1)  beats issued in the current burst.

Function
REQ-022 The state machine SHALL have four states: IDLE, BURST, GAP, HOLD.
REQ-023 IDLE->BURST SHALL occur when i_enable=1, i_occupants>=THRESHOLD and i_fifo_empty=0 are all true at an edge; in the same edge, o_beat_idx is cleared and i_mode is latched.
REQ-024 A beat SHALL occur in any cycle where the state is BURST, i_fifo_empty=0 and i_sr_ready=1; o_read_enable equals this beat condition.
REQ-025 o_read_enable SHALL be 0 in every state other than BURST, so the FIFO is never read while empty.
REQ-026 Stall: when i_fifo_empty=1 or i_sr_ready=0 in BURST, there is no beat, the state is held, and o_beat_idx is held.
REQ-027 o_sr_enable SHALL equal o_read_enable delayed by exactly one cycle, matching the FIFO read latency of 1.
REQ-028 Each beat SHALL increment o_beat_idx; the beat with o_beat_idx=BURST_LEN-1 ends the burst.
REQ-029 At the edge that ends the burst:
  - state goes to GAP when GAP>0;
  - otherwise state goes to IDLE (continuous) or HOLD (single-shot);
  - o_burst_count increments, wrapping from 2^W_CNT-1 to 0;
  - o_burst_done is 1 for exactly the following cycle.
REQ-030 GAP SHALL last exactly GAP cycles, then go to IDLE (continuous) or HOLD (single-shot).
REQ-031 HOLD->IDLE SHALL occur at the first edge with i_enable=0.
REQ-032 i_enable, i_occupants and i_mode changes during BURST or GAP SHALL be ignored; a started burst always completes.
REQ-033 In continuous mode, IDLE SHALL re-evaluate the start condition, so the minimum spacing is GAP cycles plus 1 IDLE cycle between the last beat of one burst and the first beat of the next.
REQ-034 The occupancy comparison SHALL be unsigned, W_ADDR+1 bits wide; the threshold test is >= (not ==).
REQ-035 Internal counters SHALL be sized so they never wrap within a burst or gap.

Reset
REQ-036 On an edge with i_rst=1, the block SHALL enter IDLE and clear:
  - o_sr_enable, o_burst_done, o_burst_count, o_beat_idx to 0;
  - the gap counter and latched mode to 0.
REQ-037 i_rst=1 SHALL force o_read_enable=0 combinationally in that cycle.
REQ-038 Reset SHALL take priority over every transition, including mid-BURST and mid-GAP.
REQ-039 After reset release, the next burst SHALL restart from beat 0.

Verification
REQ-040 Defaults, single-shot: occupants=27, empty=0, ready=1, enable=1:
  - 9 consecutive o_read_enable cycles starting the cycle after the start edge;
  - o_sr_enable high for the 9 cycles delayed by 1;
  - o_burst_done single pulse; o_burst_count=1;
  - HOLD until enable=0.
REQ-041 occupants=26, other inputs as REQ-040 -> no read for 50 cycles, o_busy=0.
REQ-042 Mid-burst stall: empty=1 for 2 cycles after beat 3 -> read_enable low those 2 cycles; total 9 beats over 11 BURST cycles; o_beat_idx holds at 3.
REQ-043 Continuous mode, GAP=2, occupancy held at 27 -> second burst's first beat 3 cycles after the first burst's last beat; o_burst_count=2.
REQ-044 i_rst pulse after beat 5 -> next cycle all outputs 0 and state IDLE; after release, a full 9-beat burst.
REQ-045 W_CNT=2, continuous mode, 5 bursts -> o_burst_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/row_buf_sequencer.sv
// Burst read sequencer between a row FIFO and a downstream shift register:
// waits for enough occupancy, issues BURST_LEN reads, idles GAP cycles, then re-arms.
module row_buf_sequencer #(
    parameter int ROW       = 9,
    parameter int COL       = 3,
    parameter int W_ADDR    = 8,
    parameter int BURST_LEN = ROW,
    parameter int THRESHOLD = ROW * COL,
    parameter int GAP       = 2,
    parameter int W_CNT     = 8,
    localparam int W_BEAT   = $clog2(BURST_LEN + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_mode,
    input  logic              i_fifo_empty,
    input  logic [W_ADDR:0]   i_occupants,
    input  logic              i_sr_ready,
    output logic              o_read_enable,
    output logic              o_sr_enable,
    output logic              o_busy,
    output logic              o_burst_done,
    output logic [W_CNT-1:0]  o_burst_count,
    output logic [W_BEAT-1:0] o_beat_idx
);

    // One spare bit keeps the gap counter at least 1 bit wide when GAP is 0.
    localparam int W_GAP = $clog2(GAP + 2);

    localparam logic [W_ADDR:0]   THR       = (W_ADDR + 1)'(THRESHOLD);
    localparam logic [W_BEAT-1:0] BEAT_LAST = W_BEAT'(BURST_LEN - 1);
    localparam logic [W_GAP-1:0]  GAP_LAST  = W_GAP'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W_BEAT-1:0]  beat_idx_q, beat_idx_d;
    logic [W_GAP-1:0]   gap_cnt_q, gap_cnt_d;
    logic               mode_q, mode_d;
    logic [W_CNT-1:0]   burst_cnt_q, burst_cnt_d;
    logic               burst_done_q, burst_done_d;
    logic               sr_en_q, sr_en_d;
    logic               beat_s;
    logic               start_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            beat_idx_q   <= {W_BEAT{1'b0}};
            gap_cnt_q    <= {W_GAP{1'b0}};
            mode_q       <= 1'b0;
            burst_cnt_q  <= {W_CNT{1'b0}};
            burst_done_q <= 1'b0;
            sr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            mode_q       <= mode_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_done_q <= burst_done_d;
            sr_en_q      <= sr_en_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        gap_cnt_d    = gap_cnt_q;
        mode_d       = mode_q;
        burst_cnt_d  = burst_cnt_q;
        burst_done_d = 1'b0;
        sr_en_d      = o_read_enable;
        start_s      = i_enable && (i_occupants >= THR) && !i_fifo_empty;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d    = S_BURST;
                    beat_idx_d = {W_BEAT{1'b0}};
                    mode_d     = i_mode;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (beat_s) begin
                    beat_idx_d = beat_idx_q + W_BEAT'(1'b1);
                    if (beat_idx_q == BEAT_LAST) begin
                        burst_cnt_d  = burst_cnt_q + W_CNT'(1'b1);
                        burst_done_d = 1'b1;
                        gap_cnt_d    = {W_GAP{1'b0}};
                        if (GAP > 0) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = mode_q ? S_IDLE : S_HOLD;
                        end
                    end else begin
                        state_d = S_BURST;
                    end
                end else begin
                    state_d = S_BURST;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = {W_GAP{1'b0}};
                    state_d   = mode_q ? S_IDLE : S_HOLD;
                end else begin
                    gap_cnt_d = gap_cnt_q + W_GAP'(1'b1);
                end
            end
            S_HOLD: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs; the read strobe is combinational so the FIFO sees it in the beat cycle.
    always_comb begin
        beat_s        = (state_q == S_BURST) && !i_fifo_empty && i_sr_ready;
        o_read_enable = beat_s && !i_rst;
        o_busy        = (state_q == S_BURST) || (state_q == S_GAP);
        o_sr_enable   = sr_en_q;
        o_burst_done  = burst_done_q;
        o_burst_count = burst_cnt_q;
        o_beat_idx    = beat_idx_q;
    end

endmodule

// File: tb/tb_row_buf_sequencer.sv
// Bench for row_buf_sequencer: a default instance and a short-burst, 2-bit-counter,
// no-gap instance, both checked every cycle against a behavioural model.
module tb_row_buf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, mode, empty, ready;
    logic [8:0] occ;

    logic       a_read, a_sre, a_busy, a_done;
    logic [7:0] a_cnt;
    logic [3:0] a_beat;
    logic       b_read, b_sre, b_busy, b_done;
    logic [1:0] b_cnt;
    logic [2:0] b_beat;

    row_buf_sequencer dut_a (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode(mode),
        .i_fifo_empty(empty), .i_occupants(occ), .i_sr_ready(ready),
        .o_read_enable(a_read), .o_sr_enable(a_sre), .o_busy(a_busy),
        .o_burst_done(a_done), .o_burst_count(a_cnt), .o_beat_idx(a_beat)
    );

    row_buf_sequencer #(.BURST_LEN(4), .THRESHOLD(5), .GAP(0), .W_CNT(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode(mode),
        .i_fifo_empty(empty), .i_occupants(occ), .i_sr_ready(ready),
        .o_read_enable(b_read), .o_sr_enable(b_sre), .o_busy(b_busy),
        .o_burst_done(b_done), .o_burst_count(b_cnt), .o_beat_idx(b_beat)
    );

    int checks   = 0;
    int failures = 0;

    localparam int M_IDLE = 0, M_BURST = 1, M_GAP = 2, M_HOLD = 3;

    typedef struct {
        int st; int beats; int gap_left; bit mode; int count; bit done; bit sre;
    } mdl_t;
    mdl_t ma, mb;

    typedef struct {
        bit rst; bit en; bit empty; bit ready; int occ;
        bit read; bit sre; bit busy; int beat; int count;
    } vec_t;
    vec_t tbl[7];

    bit s_read_a, s_sre_a, s_busy_a, s_done_a, s_done_b;
    int s_cnt_a, s_beat_a, s_cnt_b;

    int reads, run, maxrun, first, last, dones, stall_at;
    int runs, end1, start2, nb;
    bit prev;
    int bseq[5];
    int exp_seq[5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t n;
        n.st = M_IDLE; n.beats = 0; n.gap_left = 0; n.mode = 1'b0;
        n.count = 0; n.done = 1'b0; n.sre = 1'b0;
        return n;
    endfunction

    function automatic bit mread(mdl_t m);
        return !rst && m.st == M_BURST && !empty && ready;
    endfunction

    // One clock edge of the reference: bl beats per burst, threshold, gap length, counter width.
    function automatic mdl_t mstep(mdl_t m, int bl, int thr, int gp, int wc);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        n.sre = mread(m);
        if (rst) return mreset();
        case (m.st)
            M_IDLE: if (en && int'(occ) >= thr && !empty) begin
                n.st = M_BURST; n.beats = 0; n.mode = mode;
            end
            M_BURST: if (!empty && ready) begin
                n.beats = m.beats + 1;
                if (n.beats == bl) begin
                    n.count = (m.count + 1) % (1 << wc);
                    n.done = 1'b1;
                    if (gp > 0) begin
                        n.st = M_GAP; n.gap_left = gp;
                    end else begin
                        n.st = m.mode ? M_IDLE : M_HOLD;
                    end
                end
            end
            M_GAP: begin
                n.gap_left = m.gap_left - 1;
                if (n.gap_left == 0) n.st = m.mode ? M_IDLE : M_HOLD;
            end
            M_HOLD: if (!en) n.st = M_IDLE;
            default: n.st = M_IDLE;
        endcase
        return n;
    endfunction

    task automatic neg_check();
        chk("A.read_enable", 32'(a_read), 32'(mread(ma)));
        chk("A.sr_enable", 32'(a_sre), 32'(ma.sre));
        chk("A.busy", 32'(a_busy), 32'(ma.st == M_BURST || ma.st == M_GAP));
        chk("A.burst_done", 32'(a_done), 32'(ma.done));
        chk("A.burst_count", 32'(a_cnt), 32'(ma.count));
        chk("A.beat_idx", 32'(a_beat), 32'(ma.beats));
        chk("B.read_enable", 32'(b_read), 32'(mread(mb)));
        chk("B.sr_enable", 32'(b_sre), 32'(mb.sre));
        chk("B.busy", 32'(b_busy), 32'(mb.st == M_BURST || mb.st == M_GAP));
        chk("B.burst_done", 32'(b_done), 32'(mb.done));
        chk("B.burst_count", 32'(b_cnt), 32'(mb.count));
        chk("B.beat_idx", 32'(b_beat), 32'(mb.beats));
        s_read_a = a_read; s_sre_a = a_sre; s_busy_a = a_busy; s_done_a = a_done;
        s_cnt_a = int'(a_cnt); s_beat_a = int'(a_beat);
        s_done_b = b_done; s_cnt_b = int'(b_cnt);
    endtask

    task automatic pos_step();
        @(posedge clk);
        ma = mstep(ma, 9, 27, 2, 8);
        mb = mstep(mb, 4, 5, 0, 2);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        neg_check();
        pos_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic nominal();
        en = 1'b1; mode = 1'b0; occ = 9'd27; empty = 1'b0; ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; empty = 1'b1; ready = 1'b0; occ = 9'd0;
        @(posedge clk);
        #1;
        ma = mreset();
        mb = mreset();
        do_reset();

        // rst en empty ready occ | read sre busy beat count
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 26, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 27, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 27, 1'b1, 1'b0, 1'b1, 0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 27, 1'b0, 1'b1, 1'b1, 1, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 27, 1'b0, 1'b0, 1'b1, 1, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 27, 1'b0, 1'b0, 1'b1, 1, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 27, 1'b0, 1'b0, 1'b0, 0, 0};
        mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; empty = tbl[i].empty;
            ready = tbl[i].ready; occ = 9'(tbl[i].occ);
            @(negedge clk);
            chk($sformatf("tbl%0d.read", i), 32'(a_read), 32'(tbl[i].read));
            chk($sformatf("tbl%0d.sre", i), 32'(a_sre), 32'(tbl[i].sre));
            chk($sformatf("tbl%0d.busy", i), 32'(a_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.beat", i), 32'(a_beat), 32'(tbl[i].beat));
            chk($sformatf("tbl%0d.count", i), 32'(a_cnt), 32'(tbl[i].count));
            neg_check();
            pos_step();
        end

        // Single-shot default burst, then HOLD until enable drops.
        do_reset();
        nominal();
        reads = 0; run = 0; maxrun = 0; first = -1; dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_read_a) begin
                reads++; run++;
                if (first < 0) first = i;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (s_done_a) dones++;
        end
        chk("single.reads", 32'(reads), 32'd9);
        chk("single.consecutive", 32'(maxrun), 32'd9);
        chk("single.first_read_cycle", 32'(first), 32'd1);
        chk("single.done_pulses", 32'(dones), 32'd1);
        chk("single.burst_count", 32'(s_cnt_a), 32'd1);
        chk("single.hold_not_busy", 32'(s_busy_a), 32'd0);
        en = 1'b0;
        tick();
        en = 1'b1;
        reads = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_read_a) reads++;
        end
        chk("rearm.reads", 32'(reads), 32'd4);

        // Occupancy one below threshold never starts.
        do_reset();
        nominal();
        occ = 9'd26;
        reads = 0; dones = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_read_a) reads++;
            if (s_busy_a) dones++;
        end
        chk("below_thr.reads", 32'(reads), 32'd0);
        chk("below_thr.busy_cycles", 32'(dones), 32'd0);

        // Two-cycle empty stall after the third beat.
        do_reset();
        nominal();
        reads = 0; first = -1; last = -1; stall_at = -1;
        for (int i = 0; i < 30; i++) begin
            empty = (stall_at >= 0 && i > stall_at && i <= stall_at + 2);
            tick();
            if (empty) begin
                chk("stall.read", 32'(s_read_a), 32'd0);
                chk("stall.beat_idx", 32'(s_beat_a), 32'd3);
            end
            if (s_read_a) begin
                reads++;
                if (first < 0) first = i;
                last = i;
                if (reads == 3) stall_at = i;
            end
        end
        empty = 1'b0;
        chk("stall.reads", 32'(reads), 32'd9);
        chk("stall.burst_span", 32'(last - first + 1), 32'd11);

        // Continuous mode: spacing between bursts, and B's 2-bit counter wrap.
        do_reset();
        nominal();
        mode = 1'b1;
        runs = 0; end1 = -1; start2 = -1; nb = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_read_a && !prev) begin
                runs++;
                if (runs == 2 && start2 < 0) start2 = i;
            end
            if (!s_read_a && prev && runs == 1) end1 = i - 1;
            prev = s_read_a;
            if (i == 23) chk("cont.burst_count", 32'(s_cnt_a), 32'd2);
            if (s_done_b && nb < 5) begin
                bseq[nb] = s_cnt_b;
                nb++;
            end
        end
        chk("cont.idle_between_bursts", 32'(start2 - end1 - 1), 32'd3);
        chk("wrap.pulses", 32'(nb), 32'd5);
        for (int k = 0; k < 5; k++) chk($sformatf("wrap.count%0d", k), 32'(bseq[k]), 32'(exp_seq[k]));

        // Reset mid-burst after five beats, then a full burst.
        do_reset();
        nominal();
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_read_a) reads++;
            if (reads == 5) break;
        end
        rst = 1'b1;
        tick();
        chk("rst.read_forced_low", 32'(s_read_a), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst.read", 32'(s_read_a), 32'd0);
        chk("rst.sr_enable", 32'(s_sre_a), 32'd0);
        chk("rst.busy", 32'(s_busy_a), 32'd0);
        chk("rst.done", 32'(s_done_a), 32'd0);
        chk("rst.count", 32'(s_cnt_a), 32'd0);
        chk("rst.beat_idx", 32'(s_beat_a), 32'd0);
        reads = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (s_read_a) reads++;
        end
        chk("rst.full_burst_after", 32'(reads), 32'd9);

        // Random stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 7) != 0);
            mode  = 1'($urandom_range(0, 1));
            empty = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 3) != 0);
            occ   = 9'($urandom_range(0, 40));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
